opsum_collector: RTL and testbench
==================================

// Module: opsum_collector
// PURPOSE
//  Downstream stage of a PE. Consumes 24-bit output partial sums over the PE opsum handshake
//  (opsum_enable/opsum_noc in, opsum_ready out) and buffers them in a small FIFO.
//  Writes them to a global-buffer (GLB) write port at row-major addresses:
//  base + row*stride + col. Each job starts with a start pulse and ends with a one-cycle done pulse.
// PARAMETERS
//  DATA_W      24  psum width, equal to the PE opsum width
//  FIFO_DEPTH  8   entries in the skid FIFO; power of 2, >=2
//  ADDR_W      12  GLB word-address width
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       job start pulse, sampled in IDLE only
//  base_addr     in   ADDR_W  GLB address of element (0,0)
//  row_len       in   4       psums per row (PE f)
//  num_rows      in   4       rows per job
//  row_stride    in   ADDR_W  address step between rows
//  opsum_enable  in   1       PE psum valid
//  opsum_noc     in   DATA_W  PE psum data, signed
//  opsum_ready   out  1       collector can accept a psum
//  glb_grant     in   1       GLB write port available this cycle
//  glb_wen       out  1       GLB write strobe, registered
//  glb_addr      out  ADDR_W  GLB write address, registered
//  glb_wdata     out  DATA_W  GLB write data, registered
//  busy          out  1       high from start accept until done
//  done          out  1       one-cycle pulse after the last GLB write
// BEHAVIOUR
//  Reset: state=IDLE, FIFO emptied, all counters 0.
//   opsum_ready, glb_wen, busy and done are 0; glb_addr and glb_wdata are 0.
//  Transfer rule: a psum is accepted on a rising edge where opsum_enable & opsum_ready.
//   opsum_ready is combinational: (state==RUN) & !fifo_full & (accepted < row_len*num_rows).
//   It does not depend on opsum_enable.
//  FSM:
//   IDLE:  on start, latch all config inputs and clear counters.
//          If row_len==0 or num_rows==0, go to DONE; otherwise go to RUN.
//   RUN:   accept input and write to GLB.
//          When all psums have been accepted, go to DRAIN.
//   DRAIN: no input accepted. When the FIFO is empty and the last glb_wen has issued, go to DONE.
//   DONE:  done=1 for one cycle, then go to IDLE. busy = (state != IDLE).
//  Write side (RUN/DRAIN): on an edge with FIFO non-empty & glb_grant, pop the head.
//   Register glb_wen=1, glb_addr=row_base+col, glb_wdata=head (mode per CONFIGURATION).
//   In every other cycle glb_wen=0; glb_addr and glb_wdata hold their values.
//   Latency from accept to glb_wen is >=2 cycles: FIFO write, then output register.
//  Address generation: row_base starts at base_addr; col counts 0..row_len-1.
//   On the last column, col wraps to 0 and row_base += row_stride (ADDR_W wrap, no saturation).
//   No multiplier is used.
//  FIFO push and pop in the same cycle: occupancy unchanged. This is legal when full:
//   the pop frees the slot, but ready stays 0 because it is computed from the pre-edge full flag.
//  start while busy: ignored. Config inputs are don't-care after latching.
//  Reset mid-job: job abandoned, buffered psums discarded, no done pulse.
//  A psum accepted beyond the job count cannot occur, because ready gates it.
// CONFIGURATION
//  OPSUM_RELU_EN defined: glb_wdata = head[DATA_W-1] ? 0 : head (ReLU at writeback).
//  OPSUM_RELU_EN undefined: glb_wdata = head, bit-exact pass-through.
// STRUCTURE
//  Package opsum_pkg: DATA_W default, FSM state encoding (IDLE/RUN/DRAIN/DONE), total-count width.
//  Sub-module opsum_fifo: synchronous FIFO with DEPTH/WIDTH parameters.
//   Ports: push, pop, din, dout, full, empty; async active-high rst.
//  Top level: FSM, job counters, address generator, ReLU (when enabled), output registers.
// TESTING
//  1. row_len=3, num_rows=2, base=0x100, stride=0x10; stream 1..6 back-to-back, grant=1
//     -> writes 1..6 at 0x100,0x101,0x102,0x110,0x111,0x112; done pulses once; busy falls with done.
//  2. grant=0 for 20 cycles while the PE streams
//     -> opsum_ready drops after 8 accepts, no data lost.
//     Release grant -> all 8 written in order, then the rest.
//  3. row_len=0, start -> done 2 cycles after start, glb_wen never asserted.
//  4. Input -5 (0xFFFFFB): with OPSUM_RELU_EN, wdata=0; without, wdata=0xFFFFFB.
//  5. Assert rst after 3 of 6 psums
//     -> all outputs 0 asynchronously, no done; a new job after reset runs cleanly.
//  6. start pulsed in RUN -> ignored, config unchanged, single done at end.

Source files
------------

// File: rtl/opsum_pkg.sv
// Shared definitions for the opsum collector: data width default, FSM state
// encoding, job-count width and small arithmetic helpers.
package opsum_pkg;

  // Default psum width, equal to the PE opsum width
  localparam int DATA_W_DEF = 24;

  // Width of the row_len / num_rows configuration fields
  localparam int CFG_W = 4;

  // Width of the total psum count of a job (row_len * num_rows, max 15*15)
  localparam int TOT_W = 2 * CFG_W;

  // Collector FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Job size as a shift-and-add product; evaluated once when a job starts
  function automatic logic [TOT_W-1:0] job_total(input logic [CFG_W-1:0] len,
                                                 input logic [CFG_W-1:0] rows);
    logic [TOT_W-1:0] acc;
    acc = {TOT_W{1'b0}};
    for (int i = 0; i < CFG_W; i++) begin
      if (rows[i]) begin
        acc = acc + ({{CFG_W{1'b0}}, len} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/opsum_fifo.sv
// Synchronous skid FIFO between the PE opsum handshake and the GLB write port.
// DEPTH must be a power of two so the pointers wrap naturally.
// Simultaneous push and pop leave the occupancy unchanged, also when full.
module opsum_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == {(PTR_W + 1){1'b0}});
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO only lands when a pop frees the head slot
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;

  // Next pointer and occupancy computation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/opsum_collector.sv
// Opsum collector: accepts PE output psums, buffers them in a skid FIFO and
// writes them to the GLB at row-major addresses base + row*stride + col.
// Optional build macro OPSUM_RELU_EN clamps negative psums to zero at writeback;
// without it the data path is a bit-exact pass-through.
module opsum_collector
  import opsum_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CFG_W-1:0]  row_len,
  input  logic [CFG_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              opsum_enable,
  input  logic [DATA_W-1:0] opsum_noc,
  output logic              opsum_ready,
  input  logic              glb_grant,
  output logic              glb_wen,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [DATA_W-1:0] glb_wdata,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   row_len_q, row_len_d;
  logic [ADDR_W-1:0]  row_stride_q, row_stride_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [TOT_W-1:0]   accepted_q, accepted_d;
  logic [CFG_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic               glb_wen_q, glb_wen_d;
  logic [ADDR_W-1:0]  glb_addr_q, glb_addr_d;
  logic [DATA_W-1:0]  glb_wdata_q, glb_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ready_s;
  logic               accept_s;
  logic               pop_s;
  logic               writing_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [DATA_W-1:0]  fifo_dout_s;
  logic [DATA_W-1:0]  wb_data_s;

  opsum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (opsum_noc),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Ready is independent of opsum_enable; the count term stops over-acceptance
  assign ready_s   = (state_q == ST_RUN) & ~fifo_full_s & (accepted_q < total_q);
  assign accept_s  = opsum_enable & ready_s;
  assign writing_s = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign pop_s     = writing_s & ~fifo_empty_s & glb_grant;

`ifdef OPSUM_RELU_EN
  assign wb_data_s = fifo_dout_s[DATA_W-1] ? {DATA_W{1'b0}} : fifo_dout_s;
`else
  assign wb_data_s = fifo_dout_s;
`endif

  // FSM next state, job counters, address generator and write-port next values
  always_comb begin
    state_d      = state_q;
    row_len_d    = row_len_q;
    row_stride_d = row_stride_q;
    total_d      = total_q;
    accepted_d   = accepted_q;
    col_d        = col_q;
    row_base_d   = row_base_q;
    glb_wen_d    = 1'b0;
    glb_addr_d   = glb_addr_q;
    glb_wdata_d  = glb_wdata_q;

    if (accept_s) begin
      accepted_d = accepted_q + TOT_W'(1);
    end else begin
      accepted_d = accepted_q;
    end

    // Column wraps at row end and the row base steps by the stride (no multiplier)
    if (pop_s) begin
      glb_wen_d   = 1'b1;
      glb_addr_d  = row_base_q + ADDR_W'(col_q);
      glb_wdata_d = wb_data_s;
      if (col_q == (row_len_q - CFG_W'(1))) begin
        col_d      = {CFG_W{1'b0}};
        row_base_d = row_base_q + row_stride_q;
      end else begin
        col_d = col_q + CFG_W'(1);
      end
    end else begin
      glb_wen_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_len_d    = row_len;
          row_stride_d = row_stride;
          total_d      = job_total(row_len, num_rows);
          accepted_d   = {TOT_W{1'b0}};
          col_d        = {CFG_W{1'b0}};
          row_base_d   = base_addr;
          if ((row_len == {CFG_W{1'b0}}) || (num_rows == {CFG_W{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && ((accepted_q + TOT_W'(1)) == total_q)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // An empty FIFO here means the final pop already loaded the output register
        if (fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  // State, configuration, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_len_q    <= {CFG_W{1'b0}};
      row_stride_q <= {ADDR_W{1'b0}};
      total_q      <= {TOT_W{1'b0}};
      accepted_q   <= {TOT_W{1'b0}};
      col_q        <= {CFG_W{1'b0}};
      row_base_q   <= {ADDR_W{1'b0}};
      glb_wen_q    <= 1'b0;
      glb_addr_q   <= {ADDR_W{1'b0}};
      glb_wdata_q  <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_len_q    <= row_len_d;
      row_stride_q <= row_stride_d;
      total_q      <= total_d;
      accepted_q   <= accepted_d;
      col_q        <= col_d;
      row_base_q   <= row_base_d;
      glb_wen_q    <= glb_wen_d;
      glb_addr_q   <= glb_addr_d;
      glb_wdata_q  <= glb_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign opsum_ready = ready_s;
  assign glb_wen     = glb_wen_q;
  assign glb_addr    = glb_addr_q;
  assign glb_wdata   = glb_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_opsum_collector.sv
// Directed bench for opsum_collector: expected GLB writes come from a small
// row-major address model fed by the psums the bench sends.
module tb_opsum_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [3:0]  row_len;
  logic [3:0]  num_rows;
  logic [11:0] row_stride;
  logic        opsum_enable;
  logic [23:0] opsum_noc;
  logic        opsum_ready;
  logic        glb_grant;
  logic        glb_wen;
  logic [11:0] glb_addr;
  logic [23:0] glb_wdata;
  logic        busy;
  logic        done;

  typedef struct {
    logic [11:0] addr;
    logic [23:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          err_cnt;
  int          chk_cnt;
  int          done_cnt;
  int          d0;
  logic [11:0] m_rowbase;
  logic [11:0] m_stride;
  logic [3:0]  m_rl;
  logic [3:0]  m_col;

  opsum_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_len      (row_len),
    .num_rows     (num_rows),
    .row_stride   (row_stride),
    .opsum_enable (opsum_enable),
    .opsum_noc    (opsum_noc),
    .opsum_ready  (opsum_ready),
    .glb_grant    (glb_grant),
    .glb_wen      (glb_wen),
    .glb_addr     (glb_addr),
    .glb_wdata    (glb_wdata),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_wb(input logic [23:0] d);
`ifdef OPSUM_RELU_EN
    return d[23] ? 24'd0 : d;
`else
    return d;
`endif
  endfunction

  // Write-port monitor: every strobe must match the next expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (glb_wen) begin
        if (exp_q.size() == 0) begin
          check("wen_unexpected", 32'(glb_wen), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("glb_addr", 32'(glb_addr), 32'(mon_e.addr));
          check("glb_wdata", 32'(glb_wdata), 32'(mon_e.data));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Called at a negedge; pulses start for one rising edge and primes the model
  task automatic start_job(input logic [11:0] b, input logic [3:0] rl,
                           input logic [3:0] nr, input logic [11:0] s);
    base_addr = b; row_len = rl; num_rows = nr; row_stride = s;
    m_rowbase = b; m_stride = s; m_rl = rl; m_col = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one psum until accepted; returns at the negedge after acceptance
  task automatic send(input logic [23:0] d);
    int t;
    exp_t e;
    t = 0;
    e.addr = m_rowbase + {8'd0, m_col};
    e.data = exp_wb(d);
    exp_q.push_back(e);
    if (m_col == m_rl - 4'd1) begin
      m_col = 4'd0;
      m_rowbase = m_rowbase + m_stride;
    end else begin
      m_col = m_col + 4'd1;
    end
    opsum_noc = d;
    opsum_enable = 1'b1;
    while (!opsum_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    opsum_enable = 1'b0;
  endtask

  // Wait for done; busy must already be low and done must last one cycle
  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    err_cnt = 0; chk_cnt = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; base_addr = 12'd0; row_len = 4'd0; num_rows = 4'd0;
    row_stride = 12'd0; opsum_enable = 1'b0; opsum_noc = 24'd0; glb_grant = 1'b1;
    m_rowbase = 12'd0; m_stride = 12'd0; m_rl = 4'd1; m_col = 4'd0;
    #2;
    check("rst_ready", 32'(opsum_ready), 32'd0);
    check("rst_wen", 32'(glb_wen), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(glb_addr), 32'd0);
    check("rst_wdata", 32'(glb_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: 3x2 job streamed back-to-back with grant held high
    d0 = done_cnt;
    start_job(12'h100, 4'd3, 4'd2, 12'h010);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(opsum_ready), 32'd1);
    for (int i = 1; i <= 6; i++) send(24'(i));
    wait_done("t1");
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 2: grant withheld; FIFO fills to 8 and ready drops without data loss
    d0 = done_cnt;
    glb_grant = 1'b0;
    start_job(12'h200, 4'd4, 4'd3, 12'h020);
    for (int i = 0; i < 8; i++) send(24'h000A00 + 24'(i));
    check("t2_full_ready", 32'(opsum_ready), 32'd0);
    repeat (11) @(negedge clk);
    check("t2_still_full", 32'(opsum_ready), 32'd0);
    check("t2_no_write", 32'(exp_q.size()), 32'd8);
    glb_grant = 1'b1;
    for (int i = 8; i < 12; i++) send(24'h000A00 + 24'(i));
    wait_done("t2");
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3: empty job goes straight to done, two cycles after start
    d0 = done_cnt;
    base_addr = 12'h0; row_len = 4'd0; num_rows = 4'd5; row_stride = 12'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 4: negative psum at writeback, plus a positive one
    d0 = done_cnt;
    start_job(12'h7F0, 4'd2, 4'd1, 12'h0);
    send(24'hFFFFFB);
    send(24'h000007);
    wait_done("t4");

    // 5: reset part-way through a job; everything clears asynchronously
    glb_grant = 1'b0;
    start_job(12'h040, 4'd3, 4'd2, 12'h004);
    for (int i = 1; i <= 3; i++) send(24'h000100 + 24'(i));
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t5_ready", 32'(opsum_ready), 32'd0);
    check("t5_wen", 32'(glb_wen), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_addr", 32'(glb_addr), 32'd0);
    check("t5_wdata", 32'(glb_wdata), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    glb_grant = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_no_write", 32'(glb_wen), 32'd0);
    start_job(12'h050, 4'd2, 4'd2, 12'h100);
    for (int i = 1; i <= 4; i++) send(24'h000200 + 24'(i));
    wait_done("t5");
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 6: a second start while running is ignored
    d0 = done_cnt;
    start_job(12'h300, 4'd2, 4'd2, 12'h008);
    send(24'h000301);
    base_addr = 12'h000; row_len = 4'd5; num_rows = 4'd7; row_stride = 12'h040;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 4; i++) send(24'h000300 + 24'(i));
    wait_done("t6");
    repeat (4) @(negedge clk);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
